// File: rtl/skip_add_seq_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer: FSM state
// encodings, the datapath byte width and the legal operand-size range.
package skip_add_seq_pkg;

   // Datapath slice width; every operand is processed one slice per clock.
   localparam int BYTE_W = 8;

   // Supported operand sizes in bytes.
   localparam int NBYTES_MIN = 2;
   localparam int NBYTES_MAX = 16;

   // Sequencer states; encodings are fixed so other tools can decode them.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seqStateT;

endpackage

// File: rtl/skip_adder8.sv
// 8-bit carry-skip adder built from two 4-bit ripple blocks. When every bit
// of a block propagates, the block's carry-in is forwarded straight to its
// carry-out, so the worst-case carry path skips the ripple chain.
module skip_adder8
   import skip_add_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] s,
   output logic              co
);

   logic [BYTE_W-1:0] genBits;
   logic [BYTE_W-1:0] propBits;

   assign genBits  = a & b;
   assign propBits = a ^ b;

   // Ripple inside each 4-bit block, then pick the skip carry or the rippled
   // carry at each block boundary depending on the block propagate signal.
   always_comb begin
      logic rippleCarry;
      logic lowBlockCarry;
      s             = '0;
      co            = 1'b0;
      rippleCarry   = ci;
      lowBlockCarry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s[i]        = propBits[i] ^ rippleCarry;
         rippleCarry = genBits[i] | (propBits[i] & rippleCarry);
      end
      lowBlockCarry = (&propBits[3:0]) ? ci : rippleCarry;
      rippleCarry   = lowBlockCarry;
      for (int i = 4; i < 8; i++) begin
         s[i]        = propBits[i] ^ rippleCarry;
         rippleCarry = genBits[i] | (propBits[i] & rippleCarry);
      end
      co = (&propBits[7:4]) ? lowBlockCarry : rippleCarry;
   end

endmodule

// File: rtl/skip_add_seq.sv
// Multi-byte add/subtract sequencer. One shared skip_adder8 is reused for
// NBYTES clocks per operation, LSB byte first, with the inter-byte carry held
// in a register. Operands come in and results go out over valid/ready.
module skip_add_seq
   import skip_add_seq_pkg::*;
#(
   parameter int NBYTES = 4
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*NBYTES-1:0]      a,
   input  logic [8*NBYTES-1:0]      b,
   input  logic                     ci,
   input  logic                     sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*NBYTES-1:0]      s,
   output logic                     co,
   output logic                     ovf
);

   localparam int WIDTH = BYTE_W * NBYTES;
   localparam int IDX_W = $clog2(NBYTES);

   seqStateT          state;
   logic [WIDTH-1:0]  aReg;
   logic [WIDTH-1:0]  bReg;
   logic              carryReg;
   logic [IDX_W-1:0]  byteIdx;
   logic [BYTE_W-1:0] aByte;
   logic [BYTE_W-1:0] bByte;
   logic [BYTE_W-1:0] sumByte;
   logic              sumCarry;
   logic              lastByte;

   // Handshake flags come straight from the state register, so there is no
   // combinational path from in_valid to out_valid.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign lastByte  = (byteIdx == IDX_W'(NBYTES - 1));

   // Index mux: present operand byte k of each register to the shared adder.
   always_comb begin
      aByte = '0;
      bByte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (byteIdx == IDX_W'(i)) begin
            aByte = aReg[i*BYTE_W +: BYTE_W];
            bByte = bReg[i*BYTE_W +: BYTE_W];
         end
      end
   end

   skip_adder8 byteAdder (
      .a  (aByte),
      .b  (bByte),
      .ci (carryReg),
      .s  (sumByte),
      .co (sumCarry)
   );

   // Sequencer: accept operands in IDLE (pre-inverting b for subtract and
   // seeding the carry with 1), walk the bytes in RUN writing one result byte
   // per clock, and hold the result in DONE until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         aReg     <= '0;
         bReg     <= '0;
         carryReg <= 1'b0;
         byteIdx  <= '0;
         s        <= '0;
         co       <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  aReg     <= a;
                  bReg     <= sub ? ~b : b;
                  carryReg <= sub ? 1'b1 : ci;
                  byteIdx  <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (byteIdx == IDX_W'(i)) begin
                     s[i*BYTE_W +: BYTE_W] <= sumByte;
                  end
               end
               carryReg <= sumCarry;
               if (lastByte) begin
                  co      <= sumCarry;
                  ovf     <= (aReg[WIDTH-1] == bReg[WIDTH-1]) &&
                             (sumByte[BYTE_W-1] != aReg[WIDTH-1]);
                  byteIdx <= '0;
                  state   <= DONE;
               end else begin
                  byteIdx <= byteIdx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skip_add_seq.sv
// Directed self-checking bench for skip_add_seq with NBYTES=4. Expected
// results are hand-computed constants.
module tb_skip_add_seq;

   localparam int NBYTES = 4;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   a;
   logic [8*NBYTES-1:0]   b;
   logic                  ci;
   logic                  sub;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   s;
   logic                  co;
   logic                  ovf;

   int testsRun;
   int testsFailed;

   skip_add_seq #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .ovf       (ovf)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Wait for IDLE, present one operation, time the result latency, check the
   // result and then complete the output handshake.
   task automatic applyStimulus(input string tag,
                                input logic [31:0] opA, input logic [31:0] opB,
                                input logic opCi, input logic opSub,
                                input logic [31:0] expS, input logic expCo,
                                input logic expOvf);
      int cycles;
      cycles = 0;
      while (!in_ready && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a        = opA;
      b        = opB;
      ci       = opCi;
      sub      = opSub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({tag, "_latency"}, 32'(cycles), 32'(NBYTES));
      checkOutput({tag, "_s"}, s, expS);
      checkOutput({tag, "_co"}, 32'(co), 32'(expCo));
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   // Main directed sequence.
   initial begin
      int cycles;
      logic [31:0] heldS;
      testsRun    = 0;
      testsFailed = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_s", s, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus("add_ff_1",    32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
      applyStimulus("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
      applyStimulus("add_ci_wrap", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
      applyStimulus("sub_borrow",  32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      applyStimulus("sub_7_5",     32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
      applyStimulus("sub_ci_ign",  32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
      applyStimulus("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
      applyStimulus("sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
      applyStimulus("add_mixed",   32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);

      // Backpressure: result must sit untouched while the source keeps poking.
      a        = 32'h0F0F0F0F;
      b        = 32'h01010101;
      ci       = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("bp_latency", 32'(cycles), 32'(NBYTES));
      checkOutput("bp_s_first", s, 32'h10101010);
      heldS = s;
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         a        = 32'hDEAD0000 + 32'(i);
         b        = 32'h0000BEEF;
         sub      = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("bp_s_hold", s, heldS);
         checkOutput("bp_co_hold", 32'(co), 32'd0);
         checkOutput("bp_ovf_hold", 32'(ovf), 32'd0);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_s_delivered", s, 32'h10101010);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("bp_idle_after", 32'(in_ready), 32'd1);
      checkOutput("bp_no_restart", 32'(out_valid), 32'd0);

      // Asynchronous reset two cycles into RUN.
      a        = 32'hFFFFFFFF;
      b        = 32'h00000001;
      ci       = 1'b1;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("arst_s", s, 32'h0);
      checkOutput("arst_co", 32'(co), 32'd0);
      checkOutput("arst_ovf", 32'(ovf), 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/skip_add_seq.md
# skip_add_seq

Multi-byte add/subtract sequencer that drives one shared `skip_adder8` carry-skip datapath for `NBYTES` cycles per operation. It processes one byte per clock, LSB first, and holds the inter-byte carry in a register. Operands enter and results leave through valid/ready handshakes. The block sits between the operand source (register file / test harness) and any consumer that needs widths above 8 bits without replicating adders.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: block can accept; high only in IDLE.
- `a` input 8*NBYTES: first operand.
- `b` input 8*NBYTES: second operand.
- `ci` input 1: carry-in for add; ignored when `sub`=1.
- `sub` input 1: 1 selects a − b (two's complement).
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `s` output 8*NBYTES: registered sum/difference.
- `co` output 1: carry out of MSB; for subtract, 1 means no borrow.
- `ovf` output 1: signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: latch `a` and `b`; latch `b` bit-inverted if `sub`.
  - Load carry reg with `sub ? 1 : ci`; clear byte index k to 0; go to RUN.
- RUN
  - Each cycle, `skip_adder8` gets a_reg byte k, b_reg byte k and the carry reg.
  - Sum byte is written to s byte k; carry reg takes the adder `co`; k increments.
  - When k = NBYTES−1 is processed:
    - `co` ← adder carry.
    - `ovf` ← (a_msb == b'_msb) && (s_msb != a_msb), where b' is the possibly inverted operand.
    - Go to DONE.
- DONE
  - `out_valid`=1; `s`, `co` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- In RUN and DONE, `in_ready`=0 and `in_valid` is ignored. Operands are not re-sampled.
- No bypass: a new operation cannot be accepted in the same cycle a result is consumed.
- Arithmetic: the result is modulo 2^(8·NBYTES); no saturation.
- Reset at any time, including mid-RUN or in DONE:
  - State returns to IDLE immediately; the in-flight operation is discarded.
  - `s`=0, `co`=0, `ovf`=0, `out_valid`=0, `in_ready`=1, carry reg=0, k=0.

## Timing
- Accept edge is T0. RUN occupies edges T1..T_NBYTES.
- `out_valid` rises after edge T_NBYTES, i.e. NBYTES cycles after acceptance.
- The earliest next accept is the cycle after the result handshake. Throughput is 1 operation per NBYTES+2 cycles with `out_ready` held high.
- `s` bytes update progressively during RUN. Consumers may sample `s` only while `out_valid`=1.
- Carry path per cycle is one `skip_adder8` delay plus the mux. No combinational path from `in_valid` to `out_valid`.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the BYTE_W=8 constant;
  - the NBYTES range limits.
- Single sub-module: the existing `skip_adder8`, instantiated once. The byte select is an index mux on a_reg/b_reg.
- The rest is flat: FSM, operand registers, carry reg, index counter, result register.

## Test plan
- NBYTES=4, add, a=0x000000FF, b=0x00000001, ci=0 -> s=0x00000100, co=0, ovf=0; `out_valid` exactly 4 cycles after accept.
- Add, a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, ovf=0. Repeat with ci=1 and b=0 for the same result.
- Subtract, a=0x00000005, b=0x00000007 -> s=0xFFFFFFFE, co=0 (borrow), ovf=0. Then a=7, b=5 -> s=0x00000002, co=1.
- Signed overflow:
  - add a=0x7FFFFFFF, b=1 -> s=0x80000000, ovf=1.
  - sub a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE while toggling `in_valid` and changing a/b. Required: s, co and ovf stay stable, `in_ready`=0, no new operation starts, and the first result is delivered intact.
- Assert `rst` asynchronously 2 cycles into RUN. Required: all outputs 0 and `in_ready`=1 without waiting for a clock edge. A following add of 0x12345678 + 0x11111111 then gives s=0x23456789, co=0.
